mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the pipeline's instruction-fetch port and data-memory port onto one shared single-port memory with variable-latency req/ack handshake. Generates per-port stall signals so the IF and MEM stages hold while their access is outstanding. Sits between the pipeline top (PC/IR fetch path and ALU-address/writedata data path) and the unified memory. Data accesses have priority, with a starvation guard for fetch.

## Interface
- ADDR_W, 32, address width (word address for fetch, byte address for data, passed through unmodified)
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; range 1..15
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address (pc_out)
- if_kill  in  1  discard in-flight fetch (branch flush)
- if_rdata  out  DATA_W  fetched instruction, registered
- if_valid  out  1  one-cycle fetch completion pulse
- dm_read  in  1  data load request, held until dm_valid
- dm_write  in  1  data store request, held until dm_valid
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, registered
- dm_valid  out  1  one-cycle data completion pulse
- stall_if  out  1  hold PC/IFID
- stall_mem  out  1  hold whole pipeline (MEM not complete)
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE: eligible requesters = if_req unless if_valid high this cycle; dm_read|dm_write unless dm_valid high this cycle. Data wins, except when starve_cnt == STARVE_MAX and fetch eligible -> fetch wins. No eligible request -> stay IDLE.
- On grant: register mem_addr/mem_we/mem_wdata from the winner; enter BUSY_x. mem_req = 1 in all BUSY cycles; mem_addr/mem_we/mem_wdata stable until ack.
- BUSY_x with mem_ack: return to IDLE; pulse x_valid next cycle; on read, latch mem_rdata into x_rdata (held until next read completion for that port). Store completion leaves dm_rdata unchanged.
- dm_read and dm_write both high: treated as write.
- starve_cnt: +1 on each data grant while if_req high (saturating at STARVE_MAX); cleared on fetch grant or when if_req low in IDLE.
- if_kill in BUSY_IF or in the cycle of that ack: memory access completes normally, if_valid suppressed, if_rdata not updated. if_kill in IDLE: no effect.
- stall_if = if_req & ~if_valid | stall_mem. stall_mem = (dm_read|dm_write) & ~dm_valid. Both combinational.

## Timing
- Reset (rst low, async): state IDLE, starve_cnt 0, all outputs 0, including mem_req, which drops immediately; abandoned memory transactions are ignored, and any mem_ack arriving in IDLE is ignored.
- Minimum latency: request at T0 (IDLE) -> mem_req at T1 -> ack at T1 -> x_valid at T2. With memory latency L ack cycles after mem_req rises, x_valid is at T1+L.
- Back-to-back: x_valid cycle is IDLE, and the other port can be granted that cycle. The same port is re-granted at the earliest one cycle later.
- mem_ack is only honoured while mem_req = 1.

## Structure
- Package mem_arb_pkg: state enum (IDLE, BUSY_IF, BUSY_DM), STARVE_MAX default, grant-select encoding.
- Sub-module mem_arb_prio: combinational grant decision plus the starve_cnt register. The FSM, request latches and rdata registers stay in mem_arbiter.

## Test plan
- Fetch only, addr 0x10, ack 1 cycle after mem_req, rdata 0x00500093 -> if_valid at T2, if_rdata 0x00500093, stall_if high T0–T1, then low.
- Fetch and load simultaneous, dm_addr 0x40, ack latency 3 -> data granted first; dm_valid T4 then fetch mem_req T5; stall_mem high T0–T3.
- Store 0xDEADBEEF to 0x80 -> mem_we = 1, mem_wdata 0xDEADBEEF held until ack; dm_valid pulses; dm_rdata unchanged.
- if_req held, dm_read re-asserted continuously, STARVE_MAX = 4 -> after 4 data grants the 5th grant goes to fetch, then starve_cnt = 0.
- if_kill pulsed during BUSY_IF -> ack accepted, no if_valid, if_rdata unchanged, next fetch served normally.
- rst low in BUSY_DM -> mem_req drops immediately, outputs 0; late mem_ack after release is ignored and state stays IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the fetch/data memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } grant_e;

  localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - data-first grant decision with a fetch starvation guard
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   is_idle,
  input  logic   if_req,
  input  logic   if_elig,
  input  logic   dm_elig,
  output grant_e grant
);

  logic [3:0] starve_cnt;
  logic       at_limit;

  assign at_limit = (starve_cnt == 4'(STARVE_MAX));

  always_comb begin
    grant = GNT_NONE;
    if (is_idle) begin
      if (dm_elig && !(at_limit && if_elig)) grant = GNT_DM;
      else if (if_elig)                      grant = GNT_IF;
    end
  end

  // Counts data grants that happened while fetch was asking; saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (is_idle) begin
      if (!if_req || grant == GNT_IF)
        starve_cnt <= '0;
      else if (grant == GNT_DM && !at_limit)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and data ports onto one req/ack memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state, state_nxt;
  grant_e     grant;
  logic       if_elig, dm_elig;
  logic       kill_seen;
  logic       if_done, dm_done;

  // A port that is completing this cycle is not yet asking for its next access.
  assign if_elig   = if_req & ~if_valid;
  assign dm_elig   = (dm_read | dm_write) & ~dm_valid;
  assign stall_mem = dm_elig;
  assign stall_if  = if_elig | stall_mem;
  assign mem_req   = (state != IDLE);

  assign if_done = (state == BUSY_IF) & mem_ack & ~kill_seen & ~if_kill;
  assign dm_done = (state == BUSY_DM) & mem_ack;

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk     (clk),
    .rst     (rst),
    .is_idle (state == IDLE),
    .if_req  (if_req),
    .if_elig (if_elig),
    .dm_elig (dm_elig),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant == GNT_DM)      state_nxt = BUSY_DM;
        else if (grant == GNT_IF) state_nxt = BUSY_IF;
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      kill_seen <= 1'b0;
    end else begin
      if_valid <= if_done;
      dm_valid <= dm_done;
      if (if_done)            if_rdata <= mem_rdata;
      if (dm_done && !mem_we) dm_rdata <= mem_rdata;

      if (grant == GNT_DM) begin
        mem_addr  <= dm_addr;
        mem_we    <= dm_write;
        mem_wdata <= dm_wdata;
      end else if (grant == GNT_IF) begin
        mem_addr  <= if_addr;
        mem_we    <= 1'b0;
        mem_wdata <= '0;
      end

      // A flushed fetch still runs to its ack, but its result is dropped.
      if (grant == GNT_IF)                 kill_seen <= 1'b0;
      else if (state == BUSY_IF && if_kill) kill_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_kill = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_read = 1'b0, dm_write = 1'b0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_valid, stall_if, stall_mem;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if ({if_valid, dm_valid} !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b want 00", {if_valid, dm_valid}); end
    n_cmp++; if ({if_rdata, dm_rdata} !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, dm_rdata}); end
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== 65'h0) begin n_err++; $display("FAIL reset_mem_bus: got %h want 0", {mem_we, mem_addr, mem_wdata}); end
    n_cmp++; if ({stall_if, stall_mem} !== 2'b00) begin n_err++; $display("FAIL reset_stall: got %b want 00", {stall_if, stall_mem}); end
    rst = 1'b1;
  endtask

  task automatic test_fetch_basic();
    tick(); if_req = 1'b1; if_addr = 32'h10; #1;
    n_cmp++; if ({stall_if, mem_req} !== 2'b10) begin n_err++; $display("FAIL fetch_t0: got stall_if/mem_req %b want 10", {stall_if, mem_req}); end
    tick(); #1;
    n_cmp++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h10}) begin n_err++; $display("FAIL fetch_t1_bus: got %h want %h", {mem_req, mem_we, mem_addr}, {2'b10, 32'h10}); end
    n_cmp++; if (stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_t1_stall: got %b want 1", stall_if); end
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    tick(); mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF; #1;
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL fetch_t2_valid: got %b want 1", if_valid); end
    n_cmp++; if (if_rdata !== 32'h0050_0093) begin n_err++; $display("FAIL fetch_t2_rdata: got %h want 00500093", if_rdata); end
    n_cmp++; if ({stall_if, mem_req} !== 2'b00) begin n_err++; $display("FAIL fetch_t2_idle: got %b want 00", {stall_if, mem_req}); end
    tick(); if_req = 1'b0; #1;
    n_cmp++; if ({if_valid, if_rdata} !== {1'b0, 32'h0050_0093}) begin n_err++; $display("FAIL fetch_t3_hold: got %h want %h", {if_valid, if_rdata}, {1'b0, 32'h0050_0093}); end
  endtask

  task automatic test_load_priority();
    tick(); if_req = 1'b1; if_addr = 32'h20; dm_read = 1'b1; dm_addr = 32'h40; #1;
    n_cmp++; if ({stall_if, stall_mem} !== 2'b11) begin n_err++; $display("FAIL prio_t0_stall: got %b want 11", {stall_if, stall_mem}); end
    tick(); #1;
    n_cmp++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h40}) begin n_err++; $display("FAIL prio_t1_data_first: got %h want %h", {mem_req, mem_we, mem_addr}, {2'b10, 32'h40}); end
    tick(); #1;
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin n_err++; $display("FAIL prio_t2_hold: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h40}); end
    tick(); #1;
    n_cmp++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL prio_t3_stall: got %b want 1", stall_mem); end
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    tick(); mem_ack = 1'b0; #1;
    n_cmp++; if ({dm_valid, dm_rdata} !== {1'b1, 32'h1122_3344}) begin n_err++; $display("FAIL prio_t4_load: got %h want %h", {dm_valid, dm_rdata}, {1'b1, 32'h1122_3344}); end
    n_cmp++; if ({stall_mem, mem_req} !== 2'b00) begin n_err++; $display("FAIL prio_t4_idle: got %b want 00", {stall_mem, mem_req}); end
    tick(); dm_read = 1'b0; #1;
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h20}) begin n_err++; $display("FAIL prio_t5_fetch: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h20}); end
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    tick(); mem_ack = 1'b0; #1;
    n_cmp++; if ({if_valid, if_rdata} !== {1'b1, 32'hA5A5_A5A5}) begin n_err++; $display("FAIL prio_t6_fetch_done: got %h want %h", {if_valid, if_rdata}, {1'b1, 32'hA5A5_A5A5}); end
    tick(); if_req = 1'b0;
  endtask

  task automatic test_store();
    tick(); dm_write = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEAD_BEEF;
    tick(); #1;
    n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h80, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL store_t1_bus: got %h want %h", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h80, 32'hDEAD_BEEF}); end
    tick(); #1;
    n_cmp++; if ({mem_we, mem_wdata} !== {1'b1, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL store_t2_hold: got %h want %h", {mem_we, mem_wdata}, {1'b1, 32'hDEAD_BEEF}); end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    tick(); mem_ack = 1'b0; #1;
    n_cmp++; if ({dm_valid, dm_rdata} !== {1'b1, 32'h1122_3344}) begin n_err++; $display("FAIL store_t3_done: got %h want %h", {dm_valid, dm_rdata}, {1'b1, 32'h1122_3344}); end
    tick(); dm_write = 1'b0; #1;
    n_cmp++; if ({dm_valid, mem_req} !== 2'b00) begin n_err++; $display("FAIL store_t4_idle: got %b want 00", {dm_valid, mem_req}); end
  endtask

  task automatic test_kill();
    tick(); if_req = 1'b1; if_addr = 32'h30;
    tick(); if_kill = 1'b1; #1;
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h30}) begin n_err++; $display("FAIL kill_t1_bus: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h30}); end
    tick(); if_kill = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick(); mem_ack = 1'b0; if_addr = 32'h34; #1;
    n_cmp++; if ({if_valid, if_rdata} !== {1'b0, 32'hA5A5_A5A5}) begin n_err++; $display("FAIL kill_t3_suppress: got %h want %h", {if_valid, if_rdata}, {1'b0, 32'hA5A5_A5A5}); end
    n_cmp++; if ({stall_if, mem_req} !== 2'b10) begin n_err++; $display("FAIL kill_t3_state: got %b want 10", {stall_if, mem_req}); end
    tick(); #1;
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h34}) begin n_err++; $display("FAIL kill_t4_refetch: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h34}); end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick(); mem_ack = 1'b0; #1;
    n_cmp++; if ({if_valid, if_rdata} !== {1'b1, 32'h1234_5678}) begin n_err++; $display("FAIL kill_t5_done: got %h want %h", {if_valid, if_rdata}, {1'b1, 32'h1234_5678}); end
    tick(); if_req = 1'b0;
  endtask

  task automatic test_reset_busy();
    tick(); dm_read = 1'b1; dm_addr = 32'h44;
    tick(); #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rstb_t1_req: got %b want 1", mem_req); end
    tick(); #1; rst = 1'b0; dm_read = 1'b0; #1;
    n_cmp++; if ({mem_req, mem_we, mem_addr} !== 34'h0) begin n_err++; $display("FAIL rstb_async_drop: got %h want 0", {mem_req, mem_we, mem_addr}); end
    n_cmp++; if ({if_rdata, dm_rdata, if_valid, dm_valid} !== 66'h0) begin n_err++; $display("FAIL rstb_outputs: got %h want 0", {if_rdata, dm_rdata, if_valid, dm_valid}); end
    tick(); rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0000_0077; #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rstb_late_ack_req: got %b want 0", mem_req); end
    tick(); mem_ack = 1'b0; #1;
    n_cmp++; if ({dm_valid, dm_rdata, mem_req} !== 34'h0) begin n_err++; $display("FAIL rstb_late_ack_ignored: got %h want 0", {dm_valid, dm_rdata, mem_req}); end
    tick(); #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rstb_stays_idle: got %b want 0", mem_req); end
  endtask

  // Transaction-level reference: who owns the memory, what the winner asked for,
  // and what each port should see next, derived from the arbitration rules.
  task automatic test_random(input int ncyc);
    int          owner = 0;
    int          starve = 0;
    int          wait_ack = 0;
    bit          killed = 0, f_pend = 0, d_pend = 0, fe, de, nv_if, nv_dm, exp_sm, exp_si;
    logic [31:0] t_addr = '0, t_wdata = '0;
    logic        t_we = 1'b0;
    logic        e_if_valid = 1'b0, e_dm_valid = 1'b0;
    logic [31:0] e_if_rdata = '0, e_dm_rdata = '0;
    logic [31:0] mem [logic [31:0]];
    tick();
    for (int c = 0; c < ncyc; c++) begin
      if (e_if_valid) f_pend = 0;
      if (!f_pend) begin
        if_req = 1'($urandom_range(1, 0));
        if (if_req) begin f_pend = 1; if_addr = $urandom_range(63, 0) << 2; end
      end
      if_kill = ($urandom_range(11, 0) == 0);
      if (if_kill && f_pend) if_addr = $urandom_range(63, 0) << 2;
      if (e_dm_valid) d_pend = 0;
      if (!d_pend) begin
        dm_read  = 1'($urandom_range(1, 0));
        dm_write = 1'($urandom_range(1, 0));
        if (dm_read || dm_write) begin
          d_pend = 1; dm_addr = $urandom_range(15, 0) << 2; dm_wdata = $urandom;
        end
      end
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (owner != 0) begin
        if (wait_ack == 0) begin
          mem_ack = 1'b1;
          if (!t_we) mem_rdata = mem.exists(t_addr) ? mem[t_addr] : ~t_addr;
        end else wait_ack--;
      end else mem_ack = ($urandom_range(7, 0) == 0);
      #1;
      exp_sm = (dm_read || dm_write) && !e_dm_valid;
      exp_si = (if_req && !e_if_valid) || exp_sm;
      n_cmp++; if (mem_req !== (owner != 0)) begin n_err++; $display("FAIL rnd_mem_req c=%0d: got %b want %b", c, mem_req, owner != 0); end
      if (owner != 0) begin
        n_cmp++; if ({mem_addr, mem_we} !== {t_addr, t_we}) begin n_err++; $display("FAIL rnd_mem_addr c=%0d: got %h want %h", c, {mem_addr, mem_we}, {t_addr, t_we}); end
        if (t_we) begin n_cmp++; if (mem_wdata !== t_wdata) begin n_err++; $display("FAIL rnd_mem_wdata c=%0d: got %h want %h", c, mem_wdata, t_wdata); end end
      end
      n_cmp++; if ({if_valid, dm_valid} !== {e_if_valid, e_dm_valid}) begin n_err++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, {if_valid, dm_valid}, {e_if_valid, e_dm_valid}); end
      n_cmp++; if ({if_rdata, dm_rdata} !== {e_if_rdata, e_dm_rdata}) begin n_err++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, {if_rdata, dm_rdata}, {e_if_rdata, e_dm_rdata}); end
      n_cmp++; if ({stall_if, stall_mem} !== {exp_si, exp_sm}) begin n_err++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, {stall_if, stall_mem}, {exp_si, exp_sm}); end
      nv_if = 0; nv_dm = 0;
      if (owner == 1) begin
        if (if_kill) killed = 1;
        if (mem_ack) begin
          if (!killed) begin nv_if = 1; e_if_rdata = mem_rdata; end
          owner = 0;
        end
      end else if (owner == 2) begin
        if (mem_ack) begin
          nv_dm = 1;
          if (t_we) mem[t_addr] = t_wdata; else e_dm_rdata = mem_rdata;
          owner = 0;
        end
      end else begin
        fe = if_req && !e_if_valid;
        de = (dm_read || dm_write) && !e_dm_valid;
        if (de && !(fe && starve == 4)) begin
          owner = 2; t_addr = dm_addr; t_we = dm_write; t_wdata = dm_wdata;
          starve = !if_req ? 0 : (starve < 4 ? starve + 1 : 4);
          wait_ack = $urandom_range(3, 0);
        end else if (fe) begin
          owner = 1; t_addr = if_addr; t_we = 1'b0; starve = 0; killed = 0;
          wait_ack = $urandom_range(3, 0);
        end else if (!if_req) starve = 0;
      end
      e_if_valid = nv_if; e_dm_valid = nv_dm;
      tick();
    end
    if_req = 1'b0; if_kill = 1'b0; dm_read = 1'b0; dm_write = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch_basic();
    test_load_priority();
    test_store();
    test_kill();
    test_reset_busy();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
